// File: rtl/vga_ram_lane_streamer_pkg.sv
// Shared definitions for the VGA RAM lane streamer: state encoding and the
// default row geometry also used by the VGA RAM and its reader.
package vga_ram_lane_streamer_pkg;

  localparam int LANE_W_DEF    = 8;
  localparam int NUM_LANES_DEF = 128;
  localparam int IDX_W_DEF     = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/vga_ram_lane_streamer_lane_sel.sv
// Combinational lane selector over a packed row word; an index beyond the
// last lane falls back to lane 0.
module vga_ram_lane_sel
  import vga_ram_lane_streamer_pkg::*;
#(
  parameter int LANE_W    = LANE_W_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic [LANE_W*NUM_LANES-1:0] bus,
  input  logic [IDX_W-1:0]            idx,
  output logic [LANE_W-1:0]           lane
);

  logic [LANE_W-1:0] lanes [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lanes[g] = bus[g*LANE_W +: LANE_W];
  end

  always_comb begin
    lane = lanes[0];
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx == IDX_W'(i)) lane = lanes[i];
    end
  end

endmodule

// File: rtl/vga_ram_lane_streamer.sv
// Snapshots one VGA RAM row word and streams a wrapping run of its lanes
// over a valid/ready handshake.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no burst in progress; load_ready=1, a load may start a burst
//   ST_STREAM | burst in progress; out_valid=1 until the last beat is taken
module vga_ram_lane_streamer
  import vga_ram_lane_streamer_pkg::*;
#(
  parameter int LANE_W    = LANE_W_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANE_W*NUM_LANES-1:0] bus_in,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [IDX_W-1:0]            start_idx,
  input  logic [IDX_W:0]              count,
  output logic [LANE_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        err
);

  localparam logic [IDX_W:0]   NUM_CNT  = (IDX_W+1)'(NUM_LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  state_t                      state;
  logic [LANE_W*NUM_LANES-1:0] snap;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W:0]              rem;

  logic                        start_ok;
  logic [IDX_W-1:0]            eff_start;
  logic [IDX_W:0]              eff_cnt;
  logic [IDX_W-1:0]            idx_next;

  always_comb begin
    start_ok  = ({1'b0, start_idx} < NUM_CNT);
    eff_start = start_ok ? start_idx : '0;
    eff_cnt   = (count > NUM_CNT) ? NUM_CNT : count;
    idx_next  = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  end

  // Gated by rst so the loader never sees ready while the block is held.
  assign load_ready = (state == ST_IDLE) && !rst;
  assign out_idx    = idx;

  // out_data comes only from the snapshot, so bus_in never reaches it directly.
  vga_ram_lane_sel #(
    .LANE_W    (LANE_W),
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_lane_sel (
    .bus  (snap),
    .idx  (idx),
    .lane (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      snap      <= '0;
      idx       <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            snap <= bus_in;
            err  <= !start_ok;
            if (eff_cnt != '0) begin
              state     <= ST_STREAM;
              idx       <= eff_start;
              rem       <= eff_cnt;
              out_valid <= 1'b1;
              out_last  <= (eff_cnt == (IDX_W+1)'(1));
              busy      <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (rem == (IDX_W+1)'(1)) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              rem       <= '0;
            end else begin
              idx      <= idx_next;
              rem      <= rem - (IDX_W+1)'(1);
              out_last <= (rem == (IDX_W+1)'(2));
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_ram_lane_streamer.sv
// Self-checking bench for vga_ram_lane_streamer: directed scenarios plus
// randomized bursts compared against a lane-list reference model.
module tb_vga_ram_lane_streamer;

  localparam int LW = 8;
  localparam int NL = 128;
  localparam int IW = 8;
  localparam int BW = LW * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] bus_in;
  logic          load_valid;
  logic          load_ready;
  logic [IW-1:0] start_idx;
  logic [IW:0]   count;
  logic [LW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  int exp_idx[$];
  int exp_data[$];
  bit exp_err;
  int obs_idx[$];
  int obs_data[$];
  int obs_last[$];

  always #5 clk = ~clk;

  vga_ram_lane_streamer #(.LANE_W(LW), .NUM_LANES(NL), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (bus_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .start_idx  (start_idx),
    .count      (count),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  // Reference: the burst is simply the list of lanes start, start+1, ... mod NL.
  function automatic void model(input logic [BW-1:0] snap, input int st, input int cnt);
    int s;
    int n;
    exp_idx.delete();
    exp_data.delete();
    exp_err = (st >= NL);
    s = exp_err ? 0 : st;
    n = (cnt > NL) ? NL : cnt;
    for (int k = 0; k < n; k++) begin
      int i;
      i = (s + k) % NL;
      exp_idx.push_back(i);
      exp_data.push_back(int'(snap[i*LW +: LW]));
    end
  endfunction

  function automatic logic [BW-1:0] ramp_bus();
    logic [BW-1:0] b;
    for (int i = 0; i < NL; i++) b[i*LW +: LW] = LW'(i);
    return b;
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] b;
    for (int i = 0; i < BW/32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Called right after a negedge; returns right after the negedge following the load edge.
  task automatic do_load(input int st, input int cnt);
    load_valid = 1'b1;
    start_idx  = IW'(st);
    count      = (IW+1)'(cnt);
    model(bus_in, st, cnt);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic collect(input int ready_pct, input bit scramble, output bit timed_out);
    bit done;
    int cyc;
    done = 1'b0;
    cyc  = 0;
    obs_idx.delete();
    obs_data.delete();
    obs_last.delete();
    while (!done && cyc < 3000) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        obs_idx.push_back(int'(out_idx));
        obs_data.push_back(int'(out_data));
        obs_last.push_back(int'(out_last));
        if (out_last) done = 1'b1;
      end
      if (scramble) bus_in = rand_bus();
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (load_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        out_last !== 1'b0 || out_data !== '0 || out_idx !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b err=%b last=%b data=%h idx=%0d, required all 0",
               load_ready, out_valid, busy, err, out_last, out_data, out_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: load_ready=%b out_valid=%b, required 1 0", load_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    bit to;
    bus_in = ramp_bus();
    do_load(5, 3);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 8'd5 || out_data !== 8'd5 || busy !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_first_beat: vld=%b idx=%0d data=%0d busy=%b rdy=%b, required 1 5 5 1 0",
               out_valid, out_idx, out_data, busy, load_ready);
    end
    collect(100, 1'b0, to);
    checks++;
    if (to || obs_idx.size() != 3) begin
      errors++;
      $display("FAIL basic_beats: got %0d beats timeout=%0d, required 3", obs_idx.size(), to);
    end
    for (int k = 0; k < obs_idx.size() && k < 3; k++) begin
      checks++;
      if (obs_idx[k] != exp_idx[k] || obs_data[k] != exp_data[k] || obs_last[k] != (k == 2)) begin
        errors++;
        $display("FAIL basic_beat%0d: idx=%0d data=%0d last=%0d, required %0d %0d %0d",
                 k, obs_idx[k], obs_data[k], obs_last[k], exp_idx[k], exp_data[k], k == 2);
      end
    end
    checks++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: rdy=%b vld=%b busy=%b, required 1 0 0", load_ready, out_valid, busy);
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [BW-1:0] b;
    bus_in = rand_bus();
    do_load(126, 4);
    collect(100, 1'b0, to);
    checks++;
    if (to || obs_idx.size() != 4) begin
      errors++;
      $display("FAIL wrap_beats: got %0d beats timeout=%0d, required 4", obs_idx.size(), to);
    end
    for (int k = 0; k < obs_idx.size() && k < 4; k++) begin
      checks++;
      if (obs_idx[k] != exp_idx[k] || obs_data[k] != exp_data[k] || obs_last[k] != (k == 3)) begin
        errors++;
        $display("FAIL wrap_beat%0d: idx=%0d data=%0h last=%0d, required %0d %0h %0d",
                 k, obs_idx[k], obs_data[k], obs_last[k], exp_idx[k], exp_data[k], k == 3);
      end
    end
    @(negedge clk);
    b = '0;
    b[57*LW +: LW] = 8'hA5;
    bus_in = b;
    do_load(57, 1);
    collect(100, 1'b0, to);
    checks++;
    if (to || obs_idx.size() != 1 || obs_idx[0] != 57 || obs_data[0] != 'hA5 || obs_last[0] != 1) begin
      errors++;
      $display("FAIL lane_map: beats=%0d idx=%0d data=%0h last=%0d, required 1 57 a5 1",
               obs_idx.size(), obs_idx.size() ? obs_idx[0] : -1,
               obs_data.size() ? obs_data[0] : -1, obs_last.size() ? obs_last[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    @(negedge clk);
    bus_in = ramp_bus();
    do_load(10, 2);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 8'd10 || out_data !== 8'd10 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: vld=%b idx=%0d data=%0d last=%b, required 1 10 10 0",
                 c, out_valid, out_idx, out_data, out_last);
      end
      bus_in = rand_bus();
      @(negedge clk);
    end
    collect(100, 1'b1, to);
    checks++;
    if (to || obs_idx.size() != 2) begin
      errors++;
      $display("FAIL stall_beats: got %0d beats timeout=%0d, required 2", obs_idx.size(), to);
    end
    for (int k = 0; k < obs_idx.size() && k < 2; k++) begin
      checks++;
      if (obs_idx[k] != 10 + k || obs_data[k] != 10 + k || obs_last[k] != (k == 1)) begin
        errors++;
        $display("FAIL stall_beat%0d: idx=%0d data=%0d last=%0d, required %0d %0d %0d",
                 k, obs_idx[k], obs_data[k], obs_last[k], 10 + k, 10 + k, k == 1);
      end
    end
  endtask

  task automatic test_count_zero();
    @(negedge clk);
    bus_in = ramp_bus();
    do_load(5, 0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL count_zero%0d: vld=%b rdy=%b busy=%b, required 0 1 0", c, out_valid, load_ready, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_count_clamp();
    bit to;
    int bad;
    bus_in = ramp_bus();
    do_load(3, 300);
    collect(100, 1'b0, to);
    checks++;
    if (to || obs_idx.size() != NL || obs_idx[obs_idx.size()-1] != 2) begin
      errors++;
      $display("FAIL clamp_beats: got %0d beats timeout=%0d last_idx=%0d, required 128 0 2",
               obs_idx.size(), to, obs_idx.size() ? obs_idx[obs_idx.size()-1] : -1);
    end
    bad = 0;
    for (int k = 0; k < obs_idx.size() && k < NL; k++)
      if (obs_idx[k] != exp_idx[k] || obs_data[k] != exp_data[k] || obs_last[k] != (k == NL-1)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clamp_content: %0d beats wrong, required 0", bad);
    end
  endtask

  task automatic test_bad_start();
    bit to;
    @(negedge clk);
    bus_in = rand_bus();
    do_load(200, 3);
    checks++;
    if (err !== 1'b1 || out_idx !== 8'd0) begin
      errors++;
      $display("FAIL bad_start_err: err=%b idx=%0d, required 1 0", err, out_idx);
    end
    collect(100, 1'b0, to);
    checks++;
    if (to || obs_idx.size() != 3 || obs_idx[0] != 0 || obs_data[0] != exp_data[0] || obs_idx[2] != 2) begin
      errors++;
      $display("FAIL bad_start_beats: beats=%0d timeout=%0d, required 3 beats from lane 0", obs_idx.size(), to);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL bad_start_sticky: err=%b, required 1", err);
    end
    do_load(4, 1);
    checks++;
    if (err !== 1'b0 || out_idx !== 8'd4) begin
      errors++;
      $display("FAIL good_start_clear: err=%b idx=%0d, required 0 4", err, out_idx);
    end
    collect(100, 1'b0, to);
  endtask

  task automatic test_reset_mid_burst();
    bus_in = ramp_bus();
    @(negedge clk);
    do_load(0, 8);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_idx !== 8'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: idx=%0d vld=%b, required 1 1", out_idx, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: vld=%b busy=%b last=%b rdy=%b, required 0 0 0 0",
               out_valid, busy, out_last, load_ready);
    end
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b0 || out_idx !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL midrst_hold: rdy=%b idx=%0d data=%0d, required 0 0 0", load_ready, out_idx, out_data);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after%0d: rdy=%b vld=%b, required 1 0", c, load_ready, out_valid);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit to;
    int st;
    int cnt;
    int bad;
    for (int it = 0; it < 25; it++) begin
      bus_in = rand_bus();
      st  = ($urandom_range(3) == 0) ? $urandom_range(NL, 255) : $urandom_range(NL-1);
      cnt = ($urandom_range(7) == 0) ? $urandom_range(NL, 511) : $urandom_range(0, 40);
      do_load(st, cnt);
      checks++;
      if (err !== exp_err) begin
        errors++;
        $display("FAIL rand%0d_err: err=%b, required %0d (start=%0d)", it, err, exp_err, st);
      end
      if (exp_idx.size() == 0) begin
        checks++;
        if (out_valid !== 1'b0 || load_ready !== 1'b1) begin
          errors++;
          $display("FAIL rand%0d_zero: vld=%b rdy=%b, required 0 1", it, out_valid, load_ready);
        end
      end else begin
        collect(60, 1'b1, to);
        bad = 0;
        for (int k = 0; k < obs_idx.size() && k < exp_idx.size(); k++)
          if (obs_idx[k] != exp_idx[k] || obs_data[k] != exp_data[k] ||
              obs_last[k] != (k == exp_idx.size()-1)) bad++;
        checks++;
        if (to || bad != 0 || obs_idx.size() != exp_idx.size()) begin
          errors++;
          $display("FAIL rand%0d_burst: beats=%0d bad=%0d timeout=%0d, required %0d beats 0 bad (start=%0d cnt=%0d)",
                   it, obs_idx.size(), bad, to, exp_idx.size(), st, cnt);
        end
        checks++;
        if (load_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rand%0d_after: rdy=%b vld=%b busy=%b, required 1 0 0", it, load_ready, out_valid, busy);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus_in     = '0;
    load_valid = 1'b0;
    start_idx  = '0;
    count      = '0;
    out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_count_zero();
    test_count_clamp();
    test_bad_start();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
